// File: rtl/dht11_pkg.sv
// Shared state encoding and bus timing (in microseconds) for the DHT11 sensor emulator.
package dht11_pkg;

  localparam int unsigned US_W         = 16;
  localparam int unsigned RESP_LOW_US  = 80;
  localparam int unsigned RESP_HIGH_US = 80;
  localparam int unsigned BIT_LOW_US   = 50;
  localparam int unsigned BIT0_HIGH_US = 26;
  localparam int unsigned BIT1_HIGH_US = 70;
  localparam int unsigned END_LOW_US   = 50;
  localparam int unsigned FRAME_BITS   = 40;

  typedef enum logic [2:0] {
    IDLE,
    HOST_LOW,
    HOST_REL,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } dht_state_e;

  // True on the microsecond tick that completes a phase of dur_us ticks.
  function automatic logic phase_end(input logic tick, input logic [US_W-1:0] us,
                                     input int unsigned dur_us);
    return tick && (us == US_W'(dur_us - 1));
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module us_tick_gen #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: qualifies the host start pulse, then answers with a 40-bit frame.
// state     | meaning
// IDLE      | bus released, waiting for a fresh high-to-low edge
// HOST_LOW  | timing the host start pulse
// HOST_REL  | host released, waiting before first drive
// RESP_LOW  | response low
// RESP_HIGH | response high
// BIT_LOW   | per-bit low preamble
// BIT_HIGH  | per-bit high, width encodes the bit
// END_LOW   | closing low pulse
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned WAIT_US      = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt,
  output logic       busy,
  output logic       frame_done
);

  logic                  tick;
  logic [1:0]            sync_q, sync_d;
  logic                  din_prev_q, din_prev_d;
  logic                  din_s;
  dht_state_e            state_q, state_d;
  logic [US_W-1:0]       us_q, us_d;
  logic [5:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]            chk;
  int unsigned           hi_us;

  us_tick_gen #(.DIV(CLK_HZ / 1_000_000)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign din_s = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], dht_in};
    din_prev_d = din_s;
    state_d    = state_q;
    us_d       = us_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    chk        = (hum_int + hum_dec + temp_int + temp_dec) ^ {7'd0, corrupt};
    hi_us      = sr_q[FRAME_BITS-1] ? BIT1_HIGH_US : BIT0_HIGH_US;
    if (tick && us_q != '1) us_d = us_q + US_W'(1);

    unique case (state_q)
      IDLE: begin
        us_d = '0;
        // Edge, not level: a line still held low after a frame must not restart.
        if (!din_s && din_prev_q) state_d = HOST_LOW;
      end
      HOST_LOW: begin
        if (din_s) begin
          us_d = '0;
          if (us_q >= US_W'(START_MIN_US)) begin
            state_d = HOST_REL;
            busy_d  = 1'b1;
            sr_d    = {hum_int, hum_dec, temp_int, temp_dec, chk};
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOST_REL: begin
        if (phase_end(tick, us_q, WAIT_US)) begin
          state_d = RESP_LOW;
          us_d    = '0;
          oe_d    = 1'b1;
        end
      end
      RESP_LOW: begin
        if (phase_end(tick, us_q, RESP_LOW_US)) begin
          state_d = RESP_HIGH;
          us_d    = '0;
          oe_d    = 1'b0;
        end
      end
      RESP_HIGH: begin
        if (phase_end(tick, us_q, RESP_HIGH_US)) begin
          state_d = BIT_LOW;
          us_d    = '0;
          oe_d    = 1'b1;
          bit_d   = '0;
        end
      end
      BIT_LOW: begin
        if (phase_end(tick, us_q, BIT_LOW_US)) begin
          state_d = BIT_HIGH;
          us_d    = '0;
          oe_d    = 1'b0;
        end
      end
      BIT_HIGH: begin
        if (phase_end(tick, us_q, hi_us)) begin
          us_d = '0;
          oe_d = 1'b1;
          sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == 6'(FRAME_BITS - 1)) begin
            state_d = END_LOW;
          end else begin
            state_d = BIT_LOW;
            bit_d   = bit_q + 6'd1;
          end
        end
      end
      END_LOW: begin
        if (phase_end(tick, us_q, END_LOW_US)) begin
          state_d = IDLE;
          us_d    = '0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      din_prev_q <= 1'b1;
      state_q    <= IDLE;
      us_q       <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      din_prev_q <= din_prev_d;
      state_q    <= state_d;
      us_q       <= us_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dht_oe     = oe_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter START_MIN_US, default 18000, minimum host low time accepted as a start request.
REQ-003 Parameter WAIT_US, default 30, delay from host release to the first sensor drive.
REQ-004 clk  input  1  system clock; sole clock domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 dht_in  input  1  sampled level of the single-wire bus (asynchronous).
REQ-007 dht_oe  output  1  1 = pull bus low; 0 = release to pull-up. The top level builds the open-drain pad.
REQ-008 hum_int, hum_dec, temp_int, temp_dec  input  8 each  measurement values to report.
REQ-009 corrupt  input  1  when 1 at snapshot, transmitted checksum is XORed with 8'h01.
REQ-010 busy  output  1  high from start qualification until bus release after the end pulse.
REQ-011 frame_done  output  1  one-cycle pulse when the end pulse completes.

Function
REQ-012 dht_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized level.
REQ-013 A prescaler SHALL produce a 1-cycle tick every CLK_HZ/1_000_000 clocks; all timing SHALL count ticks (1 us resolution).
REQ-014 States: IDLE, HOST_LOW, HOST_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-015 IDLE -> HOST_LOW on synchronized low; us counter cleared.
REQ-016 HOST_LOW: line high before START_MIN_US -> IDLE (glitch rejected); line high at or after START_MIN_US -> HOST_REL.
REQ-017 On entering HOST_REL, the module SHALL snapshot the four data bytes and checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, XOR 8'h01 if corrupt. busy SHALL rise.
REQ-018 HOST_REL lasts WAIT_US, then RESP_LOW (dht_oe=1, 80 us), then RESP_HIGH (dht_oe=0, 80 us).
REQ-019 Per bit: BIT_LOW with dht_oe=1 for 50 us, then BIT_HIGH with dht_oe=0 for 26 us (bit 0) or 70 us (bit 1).
REQ-020 Bit order: 40 bits, MSB first, hum_int, hum_dec, temp_int, temp_dec, checksum. A 40-bit shift register and 6-bit bit counter SHALL be used.
REQ-021 After bit 39 high phase: END_LOW, dht_oe=1 for 50 us, then dht_oe=0, frame_done pulse, busy=0, -> IDLE.
REQ-022 dht_oe SHALL be a registered output, glitch-free, and asserted only in RESP_LOW, BIT_LOW and END_LOW.
REQ-023 Data-input changes after the snapshot SHALL NOT affect the frame in flight.
REQ-024 Bus level is ignored from HOST_REL through END_LOW; a new start is recognized only after returning to IDLE.
REQ-025 If the line is still low on return to IDLE, that SHALL NOT count as a start; a fresh high-to-low transition is required.
REQ-026 The us counter SHALL saturate and not wrap in HOST_LOW (width >= 15 bits).

Reset
REQ-027 With rst high at a clk edge, next cycle: state IDLE, dht_oe=0, busy=0, frame_done=0, counters, prescaler, shift register and synchronizer cleared (synchronizer to 1 = idle-high bus).
REQ-028 Reset mid-frame SHALL release the bus within one cycle and abandon the frame.

Structure
REQ-029 A shared package dht11_pkg SHALL hold the state enumeration and the timing constants: 80/80/50/26/70/50 us and the 40-bit frame length.
REQ-030 One sub-module, us_tick_gen (prescaler), is natural; the FSM, shifter and synchronizer stay in dht11_responder.

Verification (CLK_HZ=50_000_000, START_MIN_US=18000)
REQ-031 Host low 18 ms, release, data 0x37/0x00/0x19/0x00 -> after 30 us: 80 us low, 80 us high, then bits of 0x37,0x00,0x19,0x00,0x50; frame_done once; the controlDHT11 host decodes 0x[card-number].
REQ-032 Host low 5 ms then release -> dht_oe stays 0, busy stays 0.
REQ-033 Same as REQ-031 with corrupt=1 -> checksum byte 0x51 on the wire.
REQ-034 Change hum_int to 0xFF during bit 5 -> frame still carries 0x37.
REQ-035 Assert rst during bit 20 low phase -> dht_oe=0 next cycle; a subsequent 18 ms start yields a complete, correct frame.
REQ-036 Host holds line low 30 ms continuously -> exactly one frame after release; all bit-high widths measure 26 +/- 1 us or 70 +/- 1 us.
